icache_ctrl_responder: RTL and testbench

- Cache-side end of the icache control handshake; one instance per icache bank.
- Accepts bypass, full-flush and selective-flush requests from the cluster icache control peripheral.
- Drives the bank's tag array and bypass mux to carry them out, then returns the matching acks.
- Stalls the bank's fetch path while a tag-array operation is in progress.

---
 rtl/icache_ctrl_pkg.sv | 34 +++
 rtl/icache_ctrl_responder_tag_match.sv | 21 ++
 rtl/icache_ctrl_responder.sv | 176 +++++++++++++++++
 tb/tb_icache_ctrl_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared types and width helpers for the icache control responder.
// States, pending-operation codes and address-split widths.
package icache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_INV_ALL,
        ST_SEL_RD,
        ST_SEL_WR,
        ST_ACK,
        ST_WAIT_LOW
    } state_e;

    typedef enum logic [1:0] {
        OP_BYPASS_ON,
        OP_BYPASS_OFF,
        OP_FLUSH,
        OP_SEL_FLUSH
    } op_e;

    function automatic int set_w(input int nb_sets);
        return $clog2(nb_sets);
    endfunction

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int tag_w(input int nb_sets, input int line_bytes);
        return 32 - $clog2(nb_sets) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/icache_ctrl_responder_tag_match.sv
// Per-way tag compare: a way hits when its entry is valid and its tag matches.
// Purely combinational; no flow control.
module icache_tag_match #(
    parameter int NB_WAYS = 4,
    parameter int TAG_W   = 22
) (
    input  logic [NB_WAYS*(TAG_W+1)-1:0] rdata_i,
    input  logic [TAG_W-1:0]             tag_i,
    output logic [NB_WAYS-1:0]           hit_o
);

    // Each entry is {valid, tag}, way 0 in the LSBs.
    always_comb begin
        hit_o = '0;
        for (int w = 0; w < NB_WAYS; w++) begin
            hit_o[w] = rdata_i[w*(TAG_W+1)+TAG_W] &&
                       (rdata_i[w*(TAG_W+1) +: TAG_W] == tag_i);
        end
    end

endmodule

// File: rtl/icache_ctrl_responder.sv
// Cache-side icache control responder: bypass toggle, full flush and selective flush.
// Full flush acks 66 cycles after request (enabled, fetch idle); fetch is stalled during tag work.
module icache_ctrl_responder
    import icache_ctrl_pkg::*;
#(
    parameter int NB_SETS    = 64,
    parameter int NB_WAYS    = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 bypass_req_i,
    output logic                                 bypass_ack_o,
    input  logic                                 flush_req_i,
    output logic                                 flush_ack_o,
    input  logic                                 sel_flush_req_i,
    input  logic [31:0]                          sel_flush_addr_i,
    output logic                                 sel_flush_ack_o,
    input  logic                                 fetch_busy_i,
    output logic                                 fetch_stall_o,
    output logic                                 bypass_en_o,
    output logic                                 tag_req_o,
    output logic                                 tag_we_o,
    output logic [set_w(NB_SETS)-1:0]            tag_addr_o,
    output logic [NB_WAYS-1:0]                   tag_way_be_o,
    output logic [tag_w(NB_SETS,LINE_BYTES):0]   tag_wdata_o,
    input  logic [NB_WAYS*(tag_w(NB_SETS,LINE_BYTES)+1)-1:0] tag_rdata_i
);

    localparam int SET_W = set_w(NB_SETS);
    localparam int OFF_W = off_w(LINE_BYTES);
    localparam int TAG_W = tag_w(NB_SETS, LINE_BYTES);

    state_e               state_q;
    op_e                  op_q;
    logic                 bypass_en_q;
    logic                 flush_ack_q;
    logic                 sel_ack_q;
    logic                 stall_q;
    logic                 tag_req_q;
    logic                 tag_we_q;
    logic [SET_W-1:0]     tag_addr_q;
    logic [SET_W-1:0]     set_d;
    logic [NB_WAYS-1:0]   tag_be_q;
    logic [31-OFF_W:0]    addr_q;
    logic [NB_WAYS-1:0]   hit;
    logic                 sel_wr;
    logic                 addr_off_unused;

    assign addr_off_unused = ^sel_flush_addr_i[OFF_W-1:0];
    assign set_d           = tag_addr_q + SET_W'(1);

    icache_tag_match #(
        .NB_WAYS (NB_WAYS),
        .TAG_W   (TAG_W)
    ) u_tag_match (
        .rdata_i (tag_rdata_i),
        .tag_i   (addr_q[31-OFF_W:SET_W]),
        .hit_o   (hit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_BYPASS_ON;
            bypass_en_q <= 1'b1;
            flush_ack_q <= 1'b0;
            sel_ack_q   <= 1'b0;
            stall_q     <= 1'b0;
            tag_req_q   <= 1'b0;
            tag_we_q    <= 1'b0;
            tag_addr_q  <= '0;
            tag_be_q    <= '0;
            addr_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bypass_req_i != bypass_en_q) begin
                        op_q    <= bypass_req_i ? OP_BYPASS_ON : OP_BYPASS_OFF;
                        state_q <= ST_DRAIN;
                        stall_q <= 1'b1;
                    end else if (flush_req_i) begin
                        op_q    <= OP_FLUSH;
                        state_q <= ST_DRAIN;
                        stall_q <= 1'b1;
                    end else if (sel_flush_req_i) begin
                        op_q    <= OP_SEL_FLUSH;
                        addr_q  <= sel_flush_addr_i[31:OFF_W];
                        state_q <= ST_DRAIN;
                        stall_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!fetch_busy_i) begin
                        if (op_q == OP_BYPASS_ON) begin
                            bypass_en_q <= 1'b1;
                            stall_q     <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else if (bypass_en_q && op_q != OP_BYPASS_OFF) begin
                            // Bypassed bank holds no live lines, so flushes ack at once.
                            flush_ack_q <= (op_q == OP_FLUSH);
                            sel_ack_q   <= (op_q == OP_SEL_FLUSH);
                            stall_q     <= 1'b0;
                            state_q     <= ST_ACK;
                        end else if (op_q == OP_SEL_FLUSH) begin
                            tag_req_q  <= 1'b1;
                            tag_we_q   <= 1'b0;
                            tag_be_q   <= '0;
                            tag_addr_q <= addr_q[SET_W-1:0];
                            state_q    <= ST_SEL_RD;
                        end else begin
                            tag_req_q  <= 1'b1;
                            tag_we_q   <= 1'b1;
                            tag_be_q   <= '1;
                            tag_addr_q <= '0;
                            state_q    <= ST_INV_ALL;
                        end
                    end
                end
                ST_INV_ALL: begin
                    if (tag_addr_q == SET_W'(NB_SETS - 1)) begin
                        tag_req_q  <= 1'b0;
                        tag_we_q   <= 1'b0;
                        tag_be_q   <= '0;
                        tag_addr_q <= '0;
                        stall_q    <= 1'b0;
                        if (op_q == OP_FLUSH) begin
                            flush_ack_q <= 1'b1;
                            state_q     <= ST_ACK;
                        end else begin
                            bypass_en_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end else begin
                        tag_addr_q <= set_d;
                    end
                end
                ST_SEL_RD: begin
                    tag_req_q <= 1'b0;
                    state_q   <= ST_SEL_WR;
                end
                ST_SEL_WR: begin
                    tag_addr_q <= '0;
                    stall_q    <= 1'b0;
                    sel_ack_q  <= 1'b1;
                    state_q    <= ST_ACK;
                end
                ST_ACK: begin
                    flush_ack_q <= 1'b0;
                    sel_ack_q   <= 1'b0;
                    state_q     <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if ((op_q == OP_FLUSH) ? !flush_req_i : !sel_flush_req_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read data arrives in SEL_WR, so the invalidate write is driven straight from the compare.
    assign sel_wr          = (state_q == ST_SEL_WR);
    assign tag_req_o       = sel_wr ? |hit : tag_req_q;
    assign tag_we_o        = sel_wr ? |hit : tag_we_q;
    assign tag_way_be_o    = sel_wr ? hit  : tag_be_q;
    assign tag_addr_o      = tag_addr_q;
    assign tag_wdata_o     = '0;
    assign bypass_en_o     = bypass_en_q;
    assign bypass_ack_o    = bypass_en_q;
    assign flush_ack_o     = flush_ack_q;
    assign sel_flush_ack_o = sel_ack_q;
    assign fetch_stall_o   = stall_q;

endmodule

// File: tb/tb_icache_ctrl_responder.sv
// Directed bench for icache_ctrl_responder at default parameters.
module tb_icache_ctrl_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        bypass_req_i;
    logic        bypass_ack_o;
    logic        flush_req_i;
    logic        flush_ack_o;
    logic        sel_flush_req_i;
    logic [31:0] sel_flush_addr_i;
    logic        sel_flush_ack_o;
    logic        fetch_busy_i;
    logic        fetch_stall_o;
    logic        bypass_en_o;
    logic        tag_req_o;
    logic        tag_we_o;
    logic [5:0]  tag_addr_o;
    logic [3:0]  tag_way_be_o;
    logic [22:0] tag_wdata_o;
    logic [91:0] tag_rdata_i;

    // {bypass_ack, bypass_en, stall, flush_ack, sel_ack, req, we, addr[5:0], be[3:0]}
    logic [16:0] obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {bypass_ack_o, bypass_en_o, fetch_stall_o, flush_ack_o, sel_flush_ack_o,
                  tag_req_o, tag_we_o, tag_addr_o, tag_way_be_o};

    icache_ctrl_responder dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .bypass_req_i     (bypass_req_i),
        .bypass_ack_o     (bypass_ack_o),
        .flush_req_i      (flush_req_i),
        .flush_ack_o      (flush_ack_o),
        .sel_flush_req_i  (sel_flush_req_i),
        .sel_flush_addr_i (sel_flush_addr_i),
        .sel_flush_ack_o  (sel_flush_ack_o),
        .fetch_busy_i     (fetch_busy_i),
        .fetch_stall_o    (fetch_stall_o),
        .bypass_en_o      (bypass_en_o),
        .tag_req_o        (tag_req_o),
        .tag_we_o         (tag_we_o),
        .tag_addr_o       (tag_addr_o),
        .tag_way_be_o     (tag_way_be_o),
        .tag_wdata_o      (tag_wdata_o),
        .tag_rdata_i      (tag_rdata_i)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; bypass_req_i = 1'b1; flush_req_i = 1'b0; sel_flush_req_i = 1'b0;
        sel_flush_addr_i = '0; fetch_busy_i = 1'b0; tag_rdata_i = '0;
        step; step;
        checks++;
        if (obs !== {5'b11000, 2'b00, 6'd0, 4'd0}) begin
            errors++; $display("FAIL reset_state: got %h exp %h", obs, {5'b11000, 2'b00, 6'd0, 4'd0});
        end
        checks++;
        if (tag_wdata_o !== 23'd0) begin
            errors++; $display("FAIL reset_wdata: got %h exp 0", tag_wdata_o);
        end
        rst_i = 1'b0;
        step;
        checks++;
        if (obs !== {5'b11000, 2'b00, 6'd0, 4'd0}) begin
            errors++; $display("FAIL post_reset_idle: got %h exp %h", obs, {5'b11000, 2'b00, 6'd0, 4'd0});
        end
    endtask

    // Bypass 1->0: DRAIN, 64 set writes, bypass drops on cycle 66.
    task automatic test_enable_walk(input string tag);
        logic [16:0] exp;
        bypass_req_i = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            step;
            if (c == 1)       exp = {5'b11100, 2'b00, 6'd0, 4'h0};
            else if (c <= 65) exp = {5'b11100, 2'b11, 6'(c - 2), 4'hF};
            else              exp = {5'b00000, 2'b00, 6'd0, 4'h0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL %s c%0d: got %h exp %h", tag, c, obs, exp);
            end
            if (c >= 2 && c <= 65) begin
                checks++;
                if (tag_wdata_o !== 23'd0) begin
                    errors++; $display("FAIL %s_wdata c%0d: got %h exp 0", tag, c, tag_wdata_o);
                end
            end
        end
    endtask

    task automatic test_flush_busy;
        logic [16:0] exp;
        flush_req_i = 1'b1; fetch_busy_i = 1'b1;
        for (int c = 1; c <= 74; c++) begin
            step;
            if (c <= 5)       exp = {5'b00100, 2'b00, 6'd0, 4'h0};
            else if (c <= 69) exp = {5'b00100, 2'b11, 6'(c - 6), 4'hF};
            else if (c == 70) exp = {5'b00010, 2'b00, 6'd0, 4'h0};
            else              exp = {5'b00000, 2'b00, 6'd0, 4'h0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL flush_busy c%0d: got %h exp %h", c, obs, exp);
            end
            if (c == 5) fetch_busy_i = 1'b0;
        end
        flush_req_i = 1'b0;
        step; step;
        checks++;
        if (obs !== {5'b00000, 2'b00, 6'd0, 4'h0}) begin
            errors++; $display("FAIL flush_busy_idle: got %h exp 0", obs);
        end
    endtask

    // Set 0x12: way0 valid 0x1ABCD0, way1 invalid 0x1ABCD0, way2 valid 0x2, way3 valid 0x1ABCD0.
    task automatic test_sel_flush(input string tag, input logic [31:0] addr,
                                  input logic [3:0] exp_be);
        logic [16:0] exp;
        tag_rdata_i = {1'b1, 22'h1ABCD0, 1'b1, 22'h000002, 1'b0, 22'h1ABCD0, 1'b1, 22'h1ABCD0};
        sel_flush_addr_i = addr; sel_flush_req_i = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step;
            if (c == 1) sel_flush_addr_i = 32'h0;
            if (c == 1)      exp = {5'b00100, 2'b00, 6'd0, 4'h0};
            else if (c == 2) exp = {5'b00100, 2'b10, 6'h12, 4'h0};
            else if (c == 3) exp = {5'b00100, |exp_be, |exp_be, 6'h12, exp_be};
            else if (c == 4) exp = {5'b00001, 2'b00, 6'd0, 4'h0};
            else             exp = {5'b00000, 2'b00, 6'd0, 4'h0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL %s c%0d: got %h exp %h", tag, c, obs, exp);
            end
            if (c == 3) begin
                checks++;
                if (tag_wdata_o !== 23'd0) begin
                    errors++; $display("FAIL %s_wdata: got %h exp 0", tag, tag_wdata_o);
                end
            end
        end
        sel_flush_req_i = 1'b0;
        step; step;
    endtask

    task automatic test_priority;
        logic [16:0] exp;
        flush_req_i = 1'b1; bypass_req_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step;
            if (c == 1)      exp = {5'b00100, 2'b00, 6'd0, 4'h0};
            else if (c == 2) exp = {5'b11000, 2'b00, 6'd0, 4'h0};
            else if (c == 3) exp = {5'b11100, 2'b00, 6'd0, 4'h0};
            else if (c == 4) exp = {5'b11010, 2'b00, 6'd0, 4'h0};
            else             exp = {5'b11000, 2'b00, 6'd0, 4'h0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL priority c%0d: got %h exp %h", c, obs, exp);
            end
        end
        flush_req_i = 1'b0;
        step; step;
    endtask

    task automatic test_sel_bypassed;
        logic [16:0] exp;
        sel_flush_addr_i = 32'h6AF3_4120; sel_flush_req_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step;
            if (c == 1)      exp = {5'b11100, 2'b00, 6'd0, 4'h0};
            else if (c == 2) exp = {5'b11001, 2'b00, 6'd0, 4'h0};
            else             exp = {5'b11000, 2'b00, 6'd0, 4'h0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL sel_bypassed c%0d: got %h exp %h", c, obs, exp);
            end
        end
        sel_flush_req_i = 1'b0;
        step; step;
    endtask

    task automatic test_reset_mid_walk;
        bypass_req_i = 1'b0;
        for (int c = 1; c <= 32; c++) step;
        checks++;
        if (obs !== {5'b11100, 2'b11, 6'd30, 4'hF}) begin
            errors++; $display("FAIL mid_walk_set30: got %h exp %h", obs, {5'b11100, 2'b11, 6'd30, 4'hF});
        end
        rst_i = 1'b1; bypass_req_i = 1'b1;
        step;
        checks++;
        if (obs !== {5'b11000, 2'b00, 6'd0, 4'h0}) begin
            errors++; $display("FAIL mid_walk_reset: got %h exp %h", obs, {5'b11000, 2'b00, 6'd0, 4'h0});
        end
        rst_i = 1'b0;
        step;
        checks++;
        if (obs !== {5'b11000, 2'b00, 6'd0, 4'h0}) begin
            errors++; $display("FAIL mid_walk_idle: got %h exp %h", obs, {5'b11000, 2'b00, 6'd0, 4'h0});
        end
        test_enable_walk("rewalk");
    endtask

    initial begin
        test_reset;
        test_enable_walk("enable_walk");
        test_flush_busy;
        test_sel_flush("sel_hit", 32'h6AF3_4120, 4'b1001);
        test_sel_flush("sel_miss", 32'h0000_0D20, 4'b0000);
        test_priority;
        test_sel_bypassed;
        test_reset_mid_walk;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
